// File: rtl/chaos_pkg.sv
// Shared types and constants for the chaos-map generator family.
package chaos_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEED,
    ST_RUN,
    ST_RESEED
  } state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, maximal-length Galois feedback mask
  localparam word_t DEFAULT_TAPS      = 16'hB400;
  localparam word_t DEFAULT_ZERO_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr_galois_step.sv
// Combinational one-step advance of a 16-bit Galois LFSR.
module lfsr_galois_step
  import chaos_pkg::*;
#(
  parameter word_t TAPS = DEFAULT_TAPS
) (
  input  logic [15:0] state_i,
  output logic [15:0] next_o
);

  // Shift right; fold the taps in when the outgoing bit is set
  always_comb begin
    next_o = state_i >> 1;
    if (state_i[0]) begin
      next_o = (state_i >> 1) ^ TAPS;
    end
  end

endmodule

// File: rtl/chaos_lfsr_mixer.sv
// Seeds, periodically reseeds and whitens a Galois LFSR from a chaotic
// sample stream; emits whitened words over a valid/ready handshake.
module chaos_lfsr_mixer
  import chaos_pkg::*;
#(
  parameter word_t       TAPS          = DEFAULT_TAPS,
  parameter int unsigned RESEED_PERIOD = 256,
  parameter word_t       ZERO_SEED     = DEFAULT_ZERO_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] chaos_in,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        reseed_pulse
);

  localparam logic [15:0] CNT_LAST = 16'(RESEED_PERIOD - 1);

  state_e      state_q, state_d;
  word_t       lfsr_q, lfsr_d;
  logic [15:0] cnt_q, cnt_d;
  word_t       data_q, data_d;
  logic        valid_q, valid_d;
  logic        pulse_q, pulse_d;

  word_t       lfsr_next;
  word_t       mix;
  logic        fire;

  lfsr_galois_step #(
    .TAPS (TAPS)
  ) u_step (
    .state_i (lfsr_q),
    .next_o  (lfsr_next)
  );

  assign mix  = lfsr_q ^ chaos_in;
  assign fire = (state_q == ST_RUN) && (!valid_q || out_ready);

  // Next-state, LFSR, counter and output-register decode
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    pulse_d = 1'b0;

    // Disable wins over every running state; a held word is dropped
    if ((state_q != ST_IDLE) && !en) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          valid_d = 1'b0;
          if (en) begin
            state_d = ST_SEED;
          end
        end
        ST_SEED: begin
          lfsr_d  = (chaos_in == '0) ? ZERO_SEED : chaos_in;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (fire) begin
            data_d  = mix;
            valid_d = 1'b1;
            lfsr_d  = lfsr_next;
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = ST_RESEED;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        ST_RESEED: begin
          lfsr_d  = (mix == '0) ? ZERO_SEED : mix;
          if (out_ready) begin
            valid_d = 1'b0;
          end
          pulse_d = 1'b1;
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers, asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lfsr_q  <= ZERO_SEED;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
    end
  end

  assign out_data     = data_q;
  assign out_valid    = valid_q;
  assign reseed_pulse = pulse_q;

endmodule

// File: doc/chaos_lfsr_mixer.md
# chaos_lfsr_mixer

Downstream consumer of the quadratic chaotic map generator. Takes the free-running 16-bit chaotic sample stream and uses it to seed, periodically reseed, and whiten a 16-bit Galois LFSR. Emits whitened pseudo-random words over a valid/ready handshake to the next stage, which is a bit serializer or a test sink.

## Interface
- `TAPS`, default 16'hB400: Galois feedback mask for x^16+x^14+x^13+x^11+1 (maximal length).
- `RESEED_PERIOD`, default 256: words issued between reseeds; legal range 2..65535.
- `ZERO_SEED`, default 16'hACE1: substitute state whenever a seed or reseed would be zero.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  run enable; level-sensitive.
- `chaos_in`  in  16  chaotic sample from the map generator; one new sample per cycle, always valid.
- `out_data`  out  16  whitened word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the word.
- `reseed_pulse`  out  1  one-cycle strobe in the cycle after a reseed is applied.

## Operation
- State machine: IDLE, SEED, RUN, RESEED.
- Reset values: state=IDLE, `lfsr`=ZERO_SEED, `cnt`=0, `out_data`=0, `out_valid`=0, `reseed_pulse`=0.
- Step function: if `lfsr[0]`=1, `(lfsr>>1)^TAPS`; otherwise `lfsr>>1`.
- Fire condition: `fire` = RUN && (!out_valid || out_ready).
- IDLE
  - If `en`=1, go to SEED.
  - While in IDLE, `out_valid`=0 and `lfsr` holds.
- SEED (one cycle)
  - `lfsr` <= `chaos_in`, or ZERO_SEED if `chaos_in`=0.
  - `cnt` <= 0.
  - Go to RUN.
- RUN, on `fire`:
  - `out_data` <= `lfsr ^ chaos_in`; `out_valid` <= 1.
  - `lfsr` <= step(`lfsr`); `cnt` <= `cnt`+1.
  - If `cnt`=RESEED_PERIOD-1, go to RESEED and set `cnt` <= 0.
- RUN, not firing (`out_valid` && !`out_ready`):
  - `out_data`, `lfsr` and `cnt` all hold.
  - Upstream keeps running, so the chaos samples are dropped.
- RESEED (one cycle)
  - `lfsr` <= `lfsr ^ chaos_in`, or ZERO_SEED if that result is 0.
  - No new word is issued. `out_valid` clears if `out_ready`=1, otherwise it holds.
  - Next cycle: `reseed_pulse`=1 and state returns to RUN.
- `en`=0 in any non-IDLE state: next edge goes to IDLE and clears `out_valid`. A held word is dropped. `lfsr` is retained.
- Re-enable always passes through SEED.
- The LFSR never holds 0; the zero guard is applied at both seed points.

## Timing
- `en` rises at edge N: SEED at N+1, RUN at N+2, first `out_valid`=1 after edge N+3.
- Steady state with `out_ready`=1: one word per cycle, except a one-cycle bubble per RESEED. Throughput is RESEED_PERIOD words per RESEED_PERIOD+1 cycles.
- `out_data` is registered, with latency 1 from the `chaos_in` sample it uses.
- Stall: `out_data` is stable while `out_valid` && !`out_ready`. `out_valid` never drops without acceptance, except on `en`=0 or `rst`.
- Simultaneous accept and reseed boundary: the word is issued, then RESEED follows.
- `rst` mid-operation: all state and outputs take their reset values asynchronously, with no partial word.

## Structure
- Shared package `chaos_pkg`:
  - state enum;
  - default TAPS and ZERO_SEED constants;
  - 16-bit word typedef, reused by the map generator and the serializer.
- One sub-module, `lfsr_galois_step`: combinational next-state for a 16-bit word given TAPS. Also reused by the verification model.
- The top level holds the FSM, counter, output register and zero guards.

## Test plan
- Reset check: assert `rst` with no clocks → `out_valid`=0, `out_data`=16'h0000, internal `lfsr`=16'hACE1.
- Seed and step: `en`=1, `chaos_in` held at 16'h7EF0, `out_ready`=1.
  - Seeded `lfsr`=16'h7EF0.
  - First word is 16'h0000 (7EF0^7EF0).
  - Next `lfsr` values are 16'h3F78, then 16'h1FBC; the words are 16'h4188 and 16'h614C.
- Zero guard: `chaos_in`=16'h0000 during SEED → `lfsr`=16'hACE1.
  - With RESEED_PERIOD=2, a reseed where `lfsr^chaos_in`=0 → `lfsr`=16'hACE1.
- Reseed cadence: RESEED_PERIOD=4, `out_ready`=1 → 4 words, one bubble cycle, then `reseed_pulse`=1 for exactly one cycle; the pattern repeats.
- Backpressure: drop `out_ready` for 5 cycles mid-stream → `out_data` and `lfsr` are frozen and no words are lost or duplicated. The sequence resumes exactly at the next step value.
- Period and abort:
  - Seed 16'h0001 with RESEED_PERIOD=65535 → the state returns to 16'h0001 after exactly 65535 steps.
  - Deassert `en` during a stall → `out_valid`=0 next cycle.
  - Re-assert `en` → SEED, with first `out_valid` 3 cycles later.
